// File: rtl/mem_trace_collector_pkg.sv
// Shared types for the memory-trace collector: the queued event record,
// access-size encodings and the address-window helper used when filtering.
package mem_trace_pkg;

    localparam int TRACE_DATA_LEN = 64;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    // 3 x 64 + 3 + 1 + 1 = 197 bits
    typedef struct packed {
        logic [TRACE_DATA_LEN-1:0] addr;
        logic [TRACE_DATA_LEN-1:0] data;
        logic [TRACE_DATA_LEN-1:0] pc;
        logic [2:0]                size;
        logic                      wr;
        logic                      cached;
    } mem_trace_entry_t;

    // Window end is formed one bit wider so base + size never wraps.
    function automatic logic in_window(input logic [TRACE_DATA_LEN-1:0] a,
                                       input logic [TRACE_DATA_LEN-1:0] base,
                                       input logic [TRACE_DATA_LEN-1:0] size);
        logic [TRACE_DATA_LEN:0] x;
        logic [TRACE_DATA_LEN:0] lo;
        logic [TRACE_DATA_LEN:0] hi;
        x  = {1'b0, a};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, size};
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/mem_trace_collector_if.sv
// Event-capture and trace-sink signal bundle of the memory-trace collector.
// The collector takes the slave side; whoever feeds it and watches it takes master.
interface mem_trace_collector_if #(
    parameter int DATA_LEN   = 64,
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  a_valid;
    logic [DATA_LEN-1:0]   a_addr;
    logic [DATA_LEN-1:0]   a_data;
    logic [DATA_LEN-1:0]   a_pc;
    logic [2:0]            a_size;
    logic                  a_wr;

    logic                  b_valid;
    logic [DATA_LEN-1:0]   b_addr;
    logic [DATA_LEN-1:0]   b_data;
    logic [DATA_LEN-1:0]   b_pc;
    logic [2:0]            b_size;
    logic                  b_wr;

    logic                  flush;
    logic                  drain_en;

    logic                  mem_req;
    logic [DATA_LEN-1:0]   addr;
    logic [DATA_LEN-1:0]   data;
    logic [DATA_LEN-1:0]   pc;
    logic [2:0]            mem_size;
    logic                  mem_write_read;
    logic                  mem_cached;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output a_valid, a_addr, a_data, a_pc, a_size, a_wr,
        output b_valid, b_addr, b_data, b_pc, b_size, b_wr,
        output flush, drain_en,
        input  mem_req, addr, data, pc, mem_size, mem_write_read, mem_cached,
        input  count, overflow, drop_cnt
    );

    modport slave (
        input  a_valid, a_addr, a_data, a_pc, a_size, a_wr,
        input  b_valid, b_addr, b_data, b_pc, b_size, b_wr,
        input  flush, drain_en,
        output mem_req, addr, data, pc, mem_size, mem_write_read, mem_cached,
        output count, overflow, drop_cnt
    );

endinterface

// File: rtl/mem_trace_fifo2w.sv
// Two-write / one-read FIFO of trace entries. push0 lands ahead of push1
// when both fire; flush clears pointers and occupancy and swallows that cycle's traffic.
module mem_trace_fifo2w
    import mem_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push0,
    input  mem_trace_entry_t       din0,
    input  logic                   push1,
    input  mem_trace_entry_t       din1,
    input  logic                   pop,
    input  logic                   flush,
    output mem_trace_entry_t       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mem_trace_entry_t mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [AW-1:0] slot1;
    logic          wr0;
    logic          wr1;
    logic          rd;

    assign wr0   = push0 && !flush;
    assign wr1   = push1 && !flush;
    assign rd    = pop && !flush && (count_reg != '0);
    // The second write takes the slot after the first only when the first is used.
    assign slot1 = wr_ptr_reg + AW'(wr0);

    always_ff @(posedge clock) begin
        if (wr0) mem[wr_ptr_reg] <= din0;
        if (wr1) mem[slot1]      <= din1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(wr0) + AW'(wr1);
            rd_ptr_reg <= rd_ptr_reg + AW'(rd);
            count_reg  <= count_reg + CW'(wr0) + CW'(wr1) - CW'(rd);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/mem_trace_collector.sv
// Collects memory-access events from the cached (A) and uncached (B) LSU ports,
// queues them and emits at most one per cycle; never stalls the CPU, drops and counts instead.
// Optional address-window filter enabled by defining MEM_TRACE_FILTER_EN.
module mem_trace_collector
    import mem_trace_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_LEN   = 64,
    parameter int DROP_CNT_W = 32
`ifdef MEM_TRACE_FILTER_EN
    ,
    parameter logic [DATA_LEN-1:0] FILTER_BASE = 64'h8000_0000,
    parameter logic [DATA_LEN-1:0] FILTER_SIZE = 64'h0800_0000
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_trace_collector_if.slave  bus
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int DW1 = DROP_CNT_W + 1;

    mem_trace_entry_t      a_entry;
    mem_trace_entry_t      b_entry;
    mem_trace_entry_t      head;
    mem_trace_entry_t      out_reg;
    logic                  mem_req_reg;
    logic                  overflow_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;
    logic [DW1-1:0]        drop_sum;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         free;
    logic                  a_elig;
    logic                  b_elig;
    logic                  a_cand;
    logic                  b_cand;
    logic                  acc_a;
    logic                  acc_b;
    logic                  drop_a;
    logic                  drop_b;
    logic                  pop;

`ifdef MEM_TRACE_FILTER_EN
    assign a_elig = in_window(bus.a_addr[DATA_LEN-1:0], FILTER_BASE, FILTER_SIZE);
    assign b_elig = in_window(bus.b_addr[DATA_LEN-1:0], FILTER_BASE, FILTER_SIZE);
`else
    assign a_elig = 1'b1;
    assign b_elig = 1'b1;
`endif

    assign a_entry = '{addr: bus.a_addr[DATA_LEN-1:0], data: bus.a_data[DATA_LEN-1:0],
                       pc: bus.a_pc[DATA_LEN-1:0], size: bus.a_size, wr: bus.a_wr,
                       cached: 1'b1};
    assign b_entry = '{addr: bus.b_addr[DATA_LEN-1:0], data: bus.b_data[DATA_LEN-1:0],
                       pc: bus.b_pc[DATA_LEN-1:0], size: bus.b_size, wr: bus.b_wr,
                       cached: 1'b0};

    // Free space comes from the registered occupancy only; a pop this cycle
    // does not make room until the next one.
    always_comb begin
        free   = CW'(DEPTH) - fifo_count;
        a_cand = bus.a_valid && a_elig && !bus.flush;
        b_cand = bus.b_valid && b_elig && !bus.flush;
        acc_a  = a_cand && (free >= CW'(1));
        acc_b  = b_cand && (free >= (acc_a ? CW'(2) : CW'(1)));
        drop_a = a_cand && !acc_a;
        drop_b = b_cand && !acc_b;
        pop    = (fifo_count != '0) && bus.drain_en && !bus.flush;
    end

    mem_trace_fifo2w #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push0 (acc_a),
        .din0  (a_entry),
        .push1 (acc_b),
        .din1  (b_entry),
        .pop   (pop),
        .flush (bus.flush),
        .head  (head),
        .count (fifo_count)
    );

    assign drop_sum = {1'b0, drop_cnt_reg} + DW1'(drop_a) + DW1'(drop_b);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req_reg  <= 1'b0;
            out_reg      <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            mem_req_reg <= pop;
            if (pop) out_reg <= head;
            if (drop_a || drop_b) overflow_reg <= 1'b1;
            drop_cnt_reg <= drop_sum[DW1-1] ? '1 : drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign bus.mem_req        = mem_req_reg;
    assign bus.addr           = out_reg.addr[DATA_LEN-1:0];
    assign bus.data           = out_reg.data[DATA_LEN-1:0];
    assign bus.pc             = out_reg.pc[DATA_LEN-1:0];
    assign bus.mem_size       = out_reg.size;
    assign bus.mem_write_read = out_reg.wr;
    assign bus.mem_cached     = out_reg.cached;
    assign bus.count          = fifo_count;
    assign bus.overflow       = overflow_reg;
    assign bus.drop_cnt       = drop_cnt_reg;

endmodule
